// File: rtl/reg_alu_sequencer.sv
// rtl/reg_alu_sequencer.sv - four-state read/execute/write-back ALU sequencer for a register bank
//
// Purpose: accepts one ALU command at a time, reads two registers through the
// bank's combinational read ports, computes the result and writes it back.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   cmd_valid / cmd_ready           command handshake (ready only in IDLE)
//   cmd_op, cmd_rs1, cmd_rs2, cmd_rd  operation code and register indices
//   raddr_a, raddr_b / rdata_a, rdata_b  register bank read ports
//   we, waddr, wdata                register bank write port (pulsed in WB)
//   done                            one-cycle pulse at write-back
//   result, flag_zero, flag_carry   last completed result and flags
module reg_alu_sequencer #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [AW-1:0]    cmd_rs1,
  input  logic [AW-1:0]    cmd_rs2,
  input  logic [AW-1:0]    cmd_rd,
  output logic [AW-1:0]    raddr_a,
  output logic [AW-1:0]    raddr_b,
  input  logic [WIDTH-1:0] rdata_a,
  input  logic [WIDTH-1:0] rdata_b,
  output logic             we,
  output logic [AW-1:0]    waddr,
  output logic [WIDTH-1:0] wdata,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             flag_zero,
  output logic             flag_carry
);

  localparam int SW = $clog2(WIDTH);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SRL = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [2:0]       r_op;
  logic [AW-1:0]    r_rs1;
  logic [AW-1:0]    r_rs2;
  logic [AW-1:0]    r_rd;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_carry;
  logic [AW-1:0]    r_waddr;
  logic [WIDTH-1:0] r_result;
  logic             r_flag_zero;
  logic             r_flag_carry;

  logic             w_accept;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_alu;
  logic             w_alu_carry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // we/done come straight from the state register, so an asynchronous reset
  // during WB drops the write pulse without waiting for a clock.
  always_comb begin
    w_next_state = r_state;
    cmd_ready    = 1'b0;
    we           = 1'b0;
    done         = 1'b0;
    case (r_state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) w_next_state = READ;
      end
      READ: w_next_state = EXEC;
      EXEC: w_next_state = WB;
      WB: begin
        we           = 1'b1;
        done         = 1'b1;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  assign w_accept = cmd_valid && cmd_ready;
  assign w_sum    = {1'b0, r_a} + {1'b0, r_b};

  always_comb begin
    w_alu       = '0;
    w_alu_carry = 1'b0;
    case (r_op)
      OP_ADD: begin
        w_alu       = w_sum[WIDTH-1:0];
        w_alu_carry = w_sum[WIDTH];
      end
      OP_SUB: begin
        w_alu       = r_a - r_b;
        w_alu_carry = (r_a < r_b);
      end
      OP_AND:  w_alu = r_a & r_b;
      OP_OR:   w_alu = r_a | r_b;
      OP_XOR:  w_alu = r_a ^ r_b;
      OP_SLL:  w_alu = r_a << r_b[SW-1:0];
      OP_SRL:  w_alu = r_a >> r_b[SW-1:0];
      default: w_alu = r_a;
    endcase
  end

  // r_res doubles as the write data: it is loaded only at the EXEC edge, so
  // it holds its value through WB and afterwards until the next command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op         <= '0;
      r_rs1        <= '0;
      r_rs2        <= '0;
      r_rd         <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_res        <= '0;
      r_carry      <= 1'b0;
      r_waddr      <= '0;
      r_result     <= '0;
      r_flag_zero  <= 1'b0;
      r_flag_carry <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op  <= cmd_op;
        r_rs1 <= cmd_rs1;
        r_rs2 <= cmd_rs2;
        r_rd  <= cmd_rd;
      end
      if (r_state == READ) begin
        r_a <= rdata_a;
        r_b <= rdata_b;
      end
      if (r_state == EXEC) begin
        r_res   <= w_alu;
        r_carry <= w_alu_carry;
        r_waddr <= r_rd;
      end
      if (r_state == WB) begin
        r_result     <= r_res;
        r_flag_zero  <= (r_res == '0);
        r_flag_carry <= r_carry;
      end
    end
  end

  assign raddr_a    = r_rs1;
  assign raddr_b    = r_rs2;
  assign waddr      = r_waddr;
  assign wdata      = r_res;
  assign result     = r_result;
  assign flag_zero  = r_flag_zero;
  assign flag_carry = r_flag_carry;

endmodule

// File: tb/tb_reg_alu_sequencer.sv
// tb/tb_reg_alu_sequencer.sv - directed vector bench for reg_alu_sequencer
module tb_reg_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [2:0]  cmd_rs1, cmd_rs2, cmd_rd;
  logic [2:0]  raddr_a, raddr_b;
  logic [15:0] rdata_a, rdata_b;
  logic        we;
  logic [2:0]  waddr;
  logic [15:0] wdata;
  logic        done;
  logic [15:0] result;
  logic        flag_zero, flag_carry;

  logic [15:0] regs [8];
  logic        tb_we;
  logic [2:0]  tb_waddr;
  logic [15:0] tb_wdata;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  reg_alu_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_rs1   (cmd_rs1),
    .cmd_rs2   (cmd_rs2),
    .cmd_rd    (cmd_rd),
    .raddr_a   (raddr_a),
    .raddr_b   (raddr_b),
    .rdata_a   (rdata_a),
    .rdata_b   (rdata_b),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .done      (done),
    .result    (result),
    .flag_zero (flag_zero),
    .flag_carry(flag_carry)
  );

  // Register bank model: combinational reads, DUT write port plus a bench
  // preload port.
  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];

  always @(posedge clk) begin
    if (we) regs[waddr] <= wdata;
    else if (tb_we) regs[tb_waddr] <= tb_wdata;
  end

  typedef struct {
    logic [2:0]  op;
    logic [2:0]  rs1, rs2, rd;
    logic        pre;
    logic [15:0] a, b;
    logic [15:0] res;
    logic        c, z;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic poke(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    tb_we = 1'b1;
    tb_waddr = a;
    tb_wdata = d;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  task automatic run_cmd(input vec_t v);
    int lat;
    if (v.pre) begin
      poke(v.rs1, v.a);
      poke(v.rs2, v.b);
    end
    @(negedge clk);
    chk("ready_idle", cmd_ready, 1);
    cmd_op = v.op;
    cmd_rs1 = v.rs1;
    cmd_rs2 = v.rs2;
    cmd_rd = v.rd;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1;
    chk("ready_busy", cmd_ready, 0);
    chk("raddr_a", raddr_a, v.rs1);
    chk("raddr_b", raddr_b, v.rs2);
    while (!done && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, 3);
    chk("we", we, 1);
    chk("waddr", waddr, v.rd);
    chk("wdata", wdata, v.res);
    @(negedge clk);
    chk("we_off", we, 0);
    chk("done_off", done, 0);
    chk("result", result, v.res);
    chk("flag_carry", flag_carry, v.c);
    chk("flag_zero", flag_zero, v.z);
    chk("ready_after", cmd_ready, 1);
    chk("bank", regs[v.rd], v.res);
  endtask

  logic [2:0] bb_src [3];
  logic [2:0] bb_dst [3];
  int acc [3];
  int n_acc, n_done, n_busy;

  initial begin
    //            op      rs1   rs2   rd    pre   a         b         res       c     z
    vecs[0]  = '{3'b000, 3'd1, 3'd2, 3'd3, 1'b1, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0};
    vecs[1]  = '{3'b000, 3'd1, 3'd2, 3'd4, 1'b1, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1};
    vecs[2]  = '{3'b001, 3'd1, 3'd2, 3'd1, 1'b1, 16'h0003, 16'h0005, 16'hFFFE, 1'b1, 1'b0};
    vecs[3]  = '{3'b111, 3'd1, 3'd2, 3'd5, 1'b0, 16'h0000, 16'h0000, 16'hFFFE, 1'b0, 1'b0};
    vecs[4]  = '{3'b010, 3'd3, 3'd4, 3'd5, 1'b1, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0, 1'b0};
    vecs[5]  = '{3'b011, 3'd3, 3'd4, 3'd6, 1'b1, 16'hF0F0, 16'h3C3C, 16'hFCFC, 1'b0, 1'b0};
    vecs[6]  = '{3'b100, 3'd3, 3'd4, 3'd2, 1'b1, 16'hF0F0, 16'h3C3C, 16'hCCCC, 1'b0, 1'b0};
    vecs[7]  = '{3'b101, 3'd1, 3'd2, 3'd3, 1'b1, 16'h8001, 16'h0011, 16'h0002, 1'b0, 1'b0};
    vecs[8]  = '{3'b110, 3'd1, 3'd2, 3'd4, 1'b1, 16'h8001, 16'h0011, 16'h4000, 1'b0, 1'b0};
    vecs[9]  = '{3'b001, 3'd7, 3'd7, 3'd7, 1'b1, 16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b1};
    vecs[10] = '{3'b101, 3'd0, 3'd5, 3'd0, 1'b1, 16'h0001, 16'h00FF, 16'h8000, 1'b0, 1'b0};
    vecs[11] = '{3'b000, 3'd2, 3'd6, 3'd6, 1'b1, 16'h8000, 16'h8001, 16'h0001, 1'b1, 1'b0};

    bb_src[0] = 3'd0; bb_dst[0] = 3'd5;
    bb_src[1] = 3'd1; bb_dst[1] = 3'd6;
    bb_src[2] = 3'd2; bb_dst[2] = 3'd7;

    for (int i = 0; i < 8; i++) regs[i] = 16'h0000;
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_op = 3'd0;
    cmd_rs1 = 3'd0;
    cmd_rs2 = 3'd0;
    cmd_rd = 3'd0;
    tb_we = 1'b0;
    tb_waddr = 3'd0;
    tb_wdata = 16'h0000;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_we", we, 0);
    chk("rst_done", done, 0);
    chk("rst_waddr", waddr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_raddr_a", raddr_a, 0);
    chk("rst_raddr_b", raddr_b, 0);
    chk("rst_result", result, 0);
    chk("rst_zero", flag_zero, 0);
    chk("rst_carry", flag_carry, 0);
    rst_n = 1'b1;
    #1;
    chk("rst_ready", cmd_ready, 1);

    // Table-driven single commands
    for (int i = 0; i < 12; i++) run_cmd(vecs[i]);

    // Back-to-back: cmd_valid held high across three MOV commands
    poke(3'd0, 16'h1111);
    poke(3'd1, 16'h2222);
    poke(3'd2, 16'h3333);
    n_acc = 0;
    n_done = 0;
    n_busy = 0;
    cmd_op = 3'b111;
    cmd_rs2 = 3'd0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      if (done) n_done++;
      if (!cmd_ready) n_busy++;
      if (n_acc == 3) begin
        cmd_valid = 1'b0;
      end else if (cmd_ready) begin
        cmd_rs1 = bb_src[n_acc];
        cmd_rd = bb_dst[n_acc];
        cmd_valid = 1'b1;
        acc[n_acc] = cyc;
        n_acc++;
      end
    end
    chk("b2b_accepts", n_acc, 3);
    chk("b2b_gap1", acc[1] - acc[0], 4);
    chk("b2b_gap2", acc[2] - acc[1], 4);
    chk("b2b_done", n_done, 3);
    chk("b2b_busy", n_busy, 9);
    chk("b2b_r5", regs[5], 16'h1111);
    chk("b2b_r6", regs[6], 16'h2222);
    chk("b2b_r7", regs[7], 16'h3333);
    chk("b2b_result", result, 16'h3333);

    // Reset asserted while the command sits in EXEC
    poke(3'd1, 16'h0101);
    poke(3'd2, 16'h0202);
    poke(3'd3, 16'hBEEF);
    @(negedge clk);
    cmd_op = 3'b000;
    cmd_rs1 = 3'd1;
    cmd_rs2 = 3'd2;
    cmd_rd = 3'd3;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_we", we, 0);
    chk("mid_done", done, 0);
    chk("mid_ready", cmd_ready, 1);
    chk("mid_waddr", waddr, 0);
    chk("mid_wdata", wdata, 0);
    chk("mid_raddr_a", raddr_a, 0);
    chk("mid_raddr_b", raddr_b, 0);
    chk("mid_result", result, 0);
    chk("mid_zero", flag_zero, 0);
    chk("mid_carry", flag_carry, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mid_ready_release", cmd_ready, 1);
    n_done = 0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(negedge clk);
      if (done || we) n_done++;
    end
    chk("mid_no_write", n_done, 0);
    chk("mid_bank", regs[3], 16'hBEEF);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_alu_sequencer.md
REG_ALU_SEQUENCER -- requirements
Module: reg_alu_sequencer

Interface
REQ-001 Parameter WIDTH, default 16, data width of the register bank served.
REQ-002 Parameter DEPTH, default 8, number of registers; AW = $clog2(DEPTH).
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset: clk  in  1  clock, all state updates on rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 cmd_valid  in  1  command offered.
REQ-006 cmd_ready  out  1  block can accept a command.
REQ-007 cmd_op  in  3  operation code.
REQ-008 cmd_rs1, cmd_rs2, cmd_rd  in  AW each  source A, source B, destination register.
REQ-009 raddr_a, raddr_b  out  AW each  read addresses to the register bank.
REQ-010 rdata_a, rdata_b  in  WIDTH each  combinational read data from the register bank.
REQ-011 we  out  1; waddr  out  AW; wdata  out  WIDTH  write port to the register bank.
REQ-012 done  out  1  one-cycle pulse at write-back.
REQ-013 result  out  WIDTH; flag_zero, flag_carry  out  1 each  last completed result and flags.

Function
REQ-014 FSM states SHALL be IDLE, READ, EXEC and WB.
REQ-015 cmd_ready SHALL be 1 only in IDLE, combinationally from state.
REQ-016 A command SHALL be accepted when cmd_valid && cmd_ready at a rising edge; op, rs1, rs2 and rd are latched and the state moves IDLE->READ.
REQ-017 raddr_a and raddr_b SHALL be driven from the latched rs1 and rs2 in every state; they are 0 after reset.
REQ-018 In READ, rdata_a and rdata_b SHALL be registered into operand registers at the clock edge ending READ; the state then moves to EXEC.
REQ-019 In EXEC, the ALU result and carry SHALL be computed from the operand registers and registered; the state then moves to WB.
REQ-020 In WB, we=1, waddr=latched rd, wdata=registered result and done=1 for exactly one cycle; result and flags update at the WB edge; the state then moves to IDLE.
REQ-021 Latency: accept edge T -> we/done high during cycle T+3 -> cmd_ready high again at T+4; peak throughput is one command per 4 cycles.
REQ-022 Outside WB, we and done SHALL be 0; waddr and wdata hold their last values.
REQ-023 Operation 000 ADD: a+b mod 2^WIDTH; carry = bit WIDTH of the (WIDTH+1)-bit sum.
REQ-024 Operation 001 SUB: a-b mod 2^WIDTH; carry = 1 when a<b unsigned (borrow).
REQ-025 Operations 010 AND, 011 OR and 100 XOR SHALL compute the bitwise result; carry = 0.
REQ-026 Operation 101 SLL: a << b[$clog2(WIDTH)-1:0]; operation 110 SRL: logical shift right by the same amount; carry = 0.
REQ-027 Operation 111 MOV: result = a; b is ignored; carry = 0.
REQ-028 flag_zero SHALL be 1 when the written result equals 0.
REQ-029 rd equal to rs1 or rs2 SHALL be legal; operands are captured before the write, so the old value is used.
REQ-030 cmd_valid asserted outside IDLE SHALL be ignored; no command is queued.
REQ-031 All-ones rs1/rs2/rd (last register) SHALL be legal; there is no address wrap.

Reset
REQ-032 On rst_n low, the state SHALL go to IDLE immediately, independent of clk.
REQ-033 Reset values: we=0, done=0, waddr=0, wdata=0, raddr_a=0, raddr_b=0, result=0, flag_zero=0, flag_carry=0, and all operand and latch registers 0.
REQ-034 Reset asserted during READ, EXEC or WB SHALL abort the command with no write; a we pulse in progress is dropped combinationally.
REQ-035 After rst_n deasserts, cmd_ready=1 in the first cycle.

Verification
REQ-036 ADD: with R1=0x00FF and R2=0x0001, op=000, rs1=1, rs2=2, rd=3 -> at T+3 we=1, waddr=3, wdata=0x0100, done=1, carry=0, zero=0.
REQ-037 ADD overflow: R1=0xFFFF, R2=0x0001, rd=4 -> wdata=0x0000, flag_carry=1, flag_zero=1.
REQ-038 SUB borrow and in-place update: R1=0x0003, R2=0x0005, rd=1 -> wdata=0xFFFE, carry=1; a following MOV rs1=1 returns 0xFFFE.
REQ-039 Back-to-back handshake: cmd_valid held high with 3 commands -> accepts exactly 4 cycles apart, cmd_ready low in READ/EXEC/WB, 3 done pulses.
REQ-040 Reset mid-operation: rst_n pulsed low during EXEC -> no we pulse, all outputs at reset values, cmd_ready=1 on the first cycle after release.
REQ-041 Shifts: R1=0x8001, R2=0x0011 (amount 1) -> SLL gives 0x0002; SRL gives 0x4000; carry=0 for both.
